// File: rtl/soc_pkg.sv
// Shared SoC definitions: IO region codes, status word layout and the
// UART transmit drain state encoding.
package soc_pkg;

  localparam logic [3:0] REGION_MEM  = 4'h0;
  localparam logic [3:0] REGION_LED  = 4'h1;
  localparam logic [3:0] REGION_UART = 4'h2;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_WAIT = 2'd1,
    DONE_WAIT = 2'd2
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count and a registered read port.
// Shared by the UART transmit path and, later, the receive path.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int LEVEL_BITS = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_reg;
  logic [PTR_BITS-1:0]   rd_ptr_reg;
  logic [LEVEL_BITS-1:0] level_reg;
  logic [LEVEL_BITS-1:0] level_next;
  logic [WIDTH-1:0]      rd_data_reg;
  logic                  push;
  logic                  pop;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LEVEL_BITS'(DEPTH));
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + LEVEL_BITS'(1);
    else if (pop && !push)
      level_next = level_reg - LEVEL_BITS'(1);
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wr_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      level_reg <= level_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
      if (pop) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + PTR_BITS'(1);
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign level   = level_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer for IO region 4'h2: queues bytes from the bus and feeds them
// one at a time to the UART via its sendReq/ready handshake.
module uart_tx_fifo
  import soc_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int LEVEL_BITS = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        ovf_clr,
  output logic [31:0] status,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_ready
);

  drain_state_t          state_reg;
  logic                  tx_send_reg;
  logic                  ovf_reg;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [LEVEL_BITS-1:0] fifo_level;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH      (DEPTH),
    .LEVEL_BITS (LEVEL_BITS)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (tx_data),
    .level   (fifo_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign pop = (state_reg == IDLE) && !fifo_empty && tx_ready;

  // Each byte waits for the UART to visibly go busy and then idle again,
  // so a stale ready right after sendReq cannot trigger a second pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      tx_send_reg <= 1'b0;
    end else begin
      tx_send_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            tx_send_reg <= 1'b1;
            state_reg   <= BUSY_WAIT;
          end
        end
        BUSY_WAIT: begin
          if (!tx_ready)
            state_reg <= DONE_WAIT;
        end
        DONE_WAIT: begin
          if (tx_ready)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A fresh overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn)
      ovf_reg <= 1'b0;
    else if (wr_valid && fifo_full)
      ovf_reg <= 1'b1;
    else if (ovf_clr)
      ovf_reg <= 1'b0;
  end

  always_comb begin
    status                              = '0;
    status[ST_LEVEL_LSB +: LEVEL_BITS]  = fifo_level;
    status[ST_OVF]                      = ovf_reg;
    status[ST_FULL]                     = fifo_full;
    status[ST_EMPTY]                    = fifo_empty;
  end

  assign wr_ready = !fifo_full;
  assign tx_send  = tx_send_reg;

endmodule
